// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings shared by ALU control and the ALU
package alu_pkg;
   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SLL  = 4'b0011;
   localparam logic [3:0] ALU_SRL  = 4'b0100;
   localparam logic [3:0] ALU_SRA  = 4'b0101;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   localparam logic [3:0] ALU_SLTU = 4'b1000;
   localparam logic [3:0] ALU_XOR  = 4'b1001;
   localparam logic [3:0] ALU_NOR  = 4'b1010;
   localparam logic [3:0] ALU_LUI  = 4'b1011;
   localparam logic [3:0] ALU_SLLV = 4'b1100;
   localparam logic [3:0] ALU_SRLV = 4'b1101;
   localparam logic [3:0] ALU_SRAV = 4'b1110;
   localparam logic [3:0] ALU_RSVD = 4'b1111;
endpackage

// File: rtl/alu_if.sv
// alu_if: operand/opcode bus into the ALU and its registered result
interface alu_if;
   logic [3:0]  alu_cnt;
   logic [31:0] input1;
   logic [31:0] input2;
   logic [4:0]  shamt;
   logic [31:0] result;
   logic        zero;
   modport master (output alu_cnt, input1, input2, shamt, input result, zero);
   modport slave (input alu_cnt, input1, input2, shamt, output result, zero);
endinterface

// File: rtl/alu_shifter.sv
// alu_shifter: combinational 32-bit barrel shifter, left or right, logical or arithmetic
module alu_shifter (
   input  logic [31:0] data,
   input  logic [4:0]  amount,
   input  logic        direction,
   input  logic        arithmetic,
   output logic [31:0] out
);
   logic [31:0] fill;
   assign fill = {32{arithmetic & data[31]}} & ~(32'hffff_ffff >> amount);
   assign out = direction ? (data >> amount) | fill : data << amount;
endmodule

// File: rtl/alu.sv
// alu: MIPS execute-stage ALU with registered result and zero flag
module alu
   import alu_pkg::*;
(
   input logic clk,
   input logic rst,
   alu_if.slave bus
);
   logic        sub, lt_s, lt_u, right, arith;
   logic [32:0] sum;
   logic [31:0] sh_out, nxt;
   logic [4:0]  amount;
   assign sub = bus.alu_cnt inside {ALU_SUB, ALU_SLT, ALU_SLTU};
   assign sum = {1'b0, bus.input1} + {1'b0, bus.input2 ^ {32{sub}}} + {32'b0, sub};
   // no borrow out of A - B means A >= B unsigned
   assign lt_u = ~sum[32];
   assign lt_s = (bus.input1[31] ^ bus.input2[31]) ? bus.input1[31] : sum[31];
   assign right = bus.alu_cnt inside {ALU_SRL, ALU_SRA, ALU_SRLV, ALU_SRAV};
   assign arith = bus.alu_cnt inside {ALU_SRA, ALU_SRAV};
   assign amount = bus.alu_cnt[3] ? bus.input1[4:0] : bus.shamt;
   alu_shifter u_shifter (
      .data(bus.input2),
      .amount(amount),
      .direction(right),
      .arithmetic(arith),
      .out(sh_out)
   );
   always_comb begin
      nxt = 32'h0;
      case (bus.alu_cnt)
         ALU_AND:  nxt = bus.input1 & bus.input2;
         ALU_OR:   nxt = bus.input1 | bus.input2;
         ALU_ADD, ALU_SUB: nxt = sum[31:0];
         ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLLV, ALU_SRLV, ALU_SRAV: nxt = sh_out;
         ALU_SLT:  nxt = {31'b0, lt_s};
         ALU_SLTU: nxt = {31'b0, lt_u};
         ALU_XOR:  nxt = bus.input1 ^ bus.input2;
         ALU_NOR:  nxt = ~(bus.input1 | bus.input2);
         ALU_LUI:  nxt = {bus.input2[15:0], 16'h0000};
         default:  nxt = 32'h0;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.result <= 32'h0;
         bus.zero   <= 1'b1;
      end else begin
         bus.result <= nxt;
         bus.zero   <= nxt == 32'h0;
      end
   end
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed vectors with a scoreboard queue checked by an independent monitor
module tb_alu;
   import alu_pkg::*;
   typedef struct {
      int          idx;
      logic [31:0] res;
      logic        z;
   } exp_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail = 0;
   int   n_issued = 0;
   alu_if bus ();
   alu dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic issue(input logic r, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh, input logic [31:0] exp);
      exp_t e;
      @(negedge clk);
      rst = r;
      bus.alu_cnt = op;
      bus.input1 = a;
      bus.input2 = b;
      bus.shamt = sh;
      e.idx = n_issued;
      e.res = exp;
      e.z = exp == 32'h0;
      sb.push_back(e);
      n_issued++;
   endtask
   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++;
            if (bus.result !== e.res) begin
               n_fail++;
               $display("FAIL vec%0d result: got %08h expected %08h", e.idx, bus.result, e.res);
            end
            n_checks++;
            if (bus.zero !== e.z) begin
               n_fail++;
               $display("FAIL vec%0d zero: got %b expected %b", e.idx, bus.zero, e.z);
            end
         end
      end
   end
   initial begin
      bus.alu_cnt = ALU_ADD;
      bus.input1 = 32'h1234_5678;
      bus.input2 = 32'h0000_0001;
      bus.shamt = 5'd3;
      issue(1, ALU_ADD,  32'h1234_5678, 32'h0000_0001, 5'd3,  32'h0000_0000);
      issue(1, ALU_NOR,  32'h0000_0000, 32'h0000_0000, 5'd0,  32'h0000_0000);
      issue(0, ALU_AND,  32'h0000_0000, 32'h0000_0001, 5'd0,  32'h0000_0000);
      issue(0, ALU_SLL,  32'h0000_0001, 32'h0000_0001, 5'd1,  32'h0000_0002);
      issue(0, ALU_SRA,  32'h0000_0000, 32'h1111_1111, 5'd0,  32'h1111_1111);
      issue(0, ALU_SRA,  32'h0000_0000, 32'h8000_0000, 5'd4,  32'hF800_0000);
      issue(0, ALU_SRL,  32'h0000_0000, 32'h8000_0000, 5'd4,  32'h0800_0000);
      issue(0, ALU_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0000);
      issue(0, ALU_SUB,  32'h0000_0005, 32'h0000_0005, 5'd0,  32'h0000_0000);
      issue(0, ALU_SUB,  32'h0000_0000, 32'h0000_0001, 5'd0,  32'hFFFF_FFFF);
      issue(0, ALU_SLT,  32'h8000_0000, 32'h0000_0001, 5'd0,  32'h0000_0001);
      issue(0, ALU_SLTU, 32'h8000_0000, 32'h0000_0001, 5'd0,  32'h0000_0000);
      issue(0, ALU_SLT,  32'h0000_0007, 32'h0000_0007, 5'd0,  32'h0000_0000);
      issue(0, ALU_NOR,  32'h0000_0000, 32'h0000_0000, 5'd0,  32'hFFFF_FFFF);
      issue(0, ALU_XOR,  32'hAAAA_5555, 32'hFFFF_0000, 5'd0,  32'h5555_5555);
      issue(0, ALU_LUI,  32'hFFFF_FFFF, 32'h0000_1234, 5'd0,  32'h1234_0000);
      issue(0, ALU_SLLV, 32'h0000_0024, 32'h0000_0001, 5'd0,  32'h0000_0010);
      issue(0, ALU_SRLV, 32'hFFFF_FFE4, 32'hF000_0000, 5'd9,  32'h0F00_0000);
      issue(0, ALU_SRAV, 32'h0000_001F, 32'h8000_0000, 5'd0,  32'hFFFF_FFFF);
      issue(0, ALU_OR,   32'h0F0F_0000, 32'h0000_00F0, 5'd0,  32'h0F0F_00F0);
      issue(0, ALU_SLT,  32'h0000_0001, 32'h8000_0000, 5'd0,  32'h0000_0000);
      issue(0, ALU_SLT,  32'hFFFF_FFFF, 32'h0000_0000, 5'd0,  32'h0000_0001);
      issue(0, ALU_SLTU, 32'h0000_0001, 32'hFFFF_FFFF, 5'd0,  32'h0000_0001);
      issue(0, ALU_RSVD, 32'h0000_00FF, 32'h0000_00FF, 5'd7,  32'h0000_0000);
      issue(0, ALU_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 5'd0,  32'h8000_0000);
      issue(0, ALU_SLL,  32'hFFFF_FFFF, 32'h0000_0003, 5'd31, 32'h8000_0000);
      issue(0, ALU_SRL,  32'h0000_0000, 32'hFFFF_FFFF, 5'd31, 32'h0000_0001);
      issue(0, ALU_ADD,  32'h0000_0001, 32'h0000_0002, 5'd0,  32'h0000_0003);
      issue(1, ALU_SUB,  32'h0000_0009, 32'h0000_0002, 5'd0,  32'h0000_0000);
      issue(0, ALU_AND,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0,  32'hFFFF_FFFF);
      issue(0, ALU_AND,  32'h0000_0000, 32'hFFFF_FFFF, 5'd0,  32'h0000_0000);
      for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
      if (sb.size() > 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: %0d expected results never checked, required 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
